// File: rtl/cu_pkg.sv
// Shared definitions for the multicycle control unit: opcode map, FSM states and
// the encodings driven onto the datapath control lines.
package cu_pkg;

    localparam logic [5:0] OP_HLT = 6'b000000;
    localparam logic [5:0] OP_MTC = 6'b100000;
    localparam logic [5:0] OP_LDI = 6'b010000;
    localparam logic [5:0] OP_LUI = 6'b010001;
    localparam logic [5:0] OP_LW  = 6'b011000;
    localparam logic [5:0] OP_SW  = 6'b011001;
    localparam logic [5:0] OP_LB  = 6'b011010;
    localparam logic [5:0] OP_SB  = 6'b011011;
    localparam logic [5:0] OP_JMP = 6'b011100;
    localparam logic [5:0] OP_JR  = 6'b011101;
    localparam logic [5:0] OP_BEQ = 6'b011110;
    localparam logic [5:0] OP_BLT = 6'b011111;

    typedef enum logic [2:0] {
        S_IF,
        S_ID,
        S_EX,
        S_MEM,
        S_WB,
        S_IRQ,
        S_HALT,
        S_TRAP
    } state_e;

    localparam logic [2:0] BR_HALT = 3'b000;
    localparam logic [2:0] BR_SEQ  = 3'b011;

    localparam logic [1:0] RB_NONE = 2'b00;
    localparam logic [1:0] RB_MEM  = 2'b01;
    localparam logic [1:0] RB_ALU  = 2'b10;
    localparam logic [1:0] RB_IMM  = 2'b11;

    localparam logic [1:0] MEM_NONE = 2'b00;
    localparam logic [1:0] MEM_BYTE = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b11;

endpackage

// File: rtl/cu_decode.sv
// Combinational instruction classifier: maps the latched IR onto the class flags
// the sequencer branches on.
module cu_decode
    import cu_pkg::*;
(
    input  logic [5:0] ir,
    output logic       is_alu,
    output logic       is_imm,
    output logic       is_branch,
    output logic       is_load,
    output logic       is_store,
    output logic       is_byte,
    output logic       is_hlt,
    output logic       is_mtc,
    output logic       is_invalid
);

    always_comb begin
        is_hlt     = (ir == OP_HLT);
        is_mtc     = (ir == OP_MTC);
        is_imm     = (ir == OP_LDI) || (ir == OP_LUI);
        is_load    = (ir == OP_LW) || (ir == OP_LB);
        is_store   = (ir == OP_SW) || (ir == OP_SB);
        is_byte    = (ir == OP_LB) || (ir == OP_SB);
        // JMP/JR/BEQ/BLT share the 0111xx prefix
        is_branch  = (ir[5:2] == OP_JMP[5:2]);
        is_alu     = (ir[5:3] < 3'b011) && !is_hlt && !is_imm;
        is_invalid = !(is_alu || is_imm || is_branch || is_load || is_store || is_hlt || is_mtc);
    end

endmodule

// File: rtl/cu_sequencer.sv
// Single-clock multicycle control unit: IF->ID->EX->MEM->WB sequencer with memory
// handshake timeout, interrupt hand-off, halt and sticky trap.
module cu_sequencer
    import cu_pkg::*;
#(
    parameter int unsigned         ALU_OP_W    = 5,
    parameter logic [ALU_OP_W-1:0] ADDI_OP     = ALU_OP_W'(5'b10010),
    parameter int unsigned         MEM_TIMEOUT = 15,
    parameter bit                  SKIP_MEM    = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          opcode,
    input  logic                instr_valid,
    input  logic                mem_ready,
    input  logic                irq_ack,
    input  logic                resume,
    output logic [4:0]          stage,
    output logic                reg_read,
    output logic                reg_write,
    output logic [ALU_OP_W-1:0] alu_opcode,
    output logic [2:0]          branch_opcode,
    output logic [1:0]          mem_read,
    output logic [1:0]          mem_write,
    output logic [1:0]          rb_mux_opcode,
    output logic                interrupt,
    output logic                halted,
    output logic                trap
);

    state_e     state_q, state_d;
    logic [5:0] ir_q, ir_d;
    logic [7:0] wait_q, wait_d, wait_inc;

    logic is_alu, is_imm, is_branch, is_load, is_store, is_byte, is_hlt, is_mtc, is_invalid;
    logic is_mem;

    logic [4:0]          stage_q, stage_d;
    logic                reg_read_q, reg_read_d;
    logic                reg_write_q, reg_write_d;
    logic [ALU_OP_W-1:0] alu_q, alu_d;
    logic [2:0]          branch_q, branch_d;
    logic [1:0]          mem_read_q, mem_read_d;
    logic [1:0]          mem_write_q, mem_write_d;
    logic [1:0]          rb_mux_q, rb_mux_d;
    logic                interrupt_q, interrupt_d;
    logic                halted_q, halted_d;
    logic                trap_q, trap_d;

    cu_decode u_decode (
        .ir         (ir_q),
        .is_alu     (is_alu),
        .is_imm     (is_imm),
        .is_branch  (is_branch),
        .is_load    (is_load),
        .is_store   (is_store),
        .is_byte    (is_byte),
        .is_hlt     (is_hlt),
        .is_mtc     (is_mtc),
        .is_invalid (is_invalid)
    );

    assign is_mem   = is_load || is_store;
    assign wait_inc = wait_q + 8'd1;

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        wait_d  = wait_q;
        unique case (state_q)
            S_IF: begin
                if (instr_valid) begin
                    ir_d    = opcode;
                    state_d = S_ID;
                end
            end
            S_ID: begin
                if (is_invalid)  state_d = S_TRAP;
                else if (is_mtc) state_d = S_IRQ;
                else             state_d = S_EX;
            end
            S_EX: begin
                wait_d = '0;
                if (is_hlt)                  state_d = S_HALT;
                else if (is_mem || !SKIP_MEM) state_d = S_MEM;
                else                         state_d = S_WB;
            end
            S_MEM: begin
                if (!is_mem) begin
                    state_d = S_WB;
                end else if (mem_ready) begin
                    // a late ready on the timeout cycle still completes the access
                    state_d = S_WB;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_inc;
                    if (wait_inc == 8'(MEM_TIMEOUT)) state_d = S_TRAP;
                end
            end
            S_WB:    state_d = S_IF;
            S_IRQ:   if (irq_ack) state_d = S_IF;
            S_HALT:  if (resume) state_d = S_IF;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    // Outputs are registered from the state being entered; IR-dependent values only
    // appear from EX onwards, when ir_q is already stable.
    always_comb begin
        stage_d     = '0;
        reg_read_d  = 1'b0;
        reg_write_d = 1'b0;
        alu_d       = '0;
        branch_d    = BR_SEQ;
        mem_read_d  = MEM_NONE;
        mem_write_d = MEM_NONE;
        rb_mux_d    = RB_NONE;
        interrupt_d = 1'b0;
        halted_d    = 1'b0;
        trap_d      = 1'b0;
        unique case (state_d)
            S_IF: stage_d = 5'b00001;
            S_ID: stage_d = 5'b00010;
            S_EX, S_MEM, S_WB: begin
                if (state_d == S_EX)       stage_d = 5'b00100;
                else if (state_d == S_MEM) stage_d = 5'b01000;
                else                       stage_d = 5'b10000;
                reg_read_d = !is_hlt && (state_d != S_WB);
                if (is_alu || (is_branch && ir_q[1])) alu_d = ir_q[ALU_OP_W-1:0];
                else if (is_mem)                      alu_d = ADDI_OP;
                if (is_branch)   branch_d = {1'b1, ir_q[1:0]};
                else if (is_hlt) branch_d = BR_HALT;
                if (state_d == S_MEM) begin
                    if (is_load)  mem_read_d  = is_byte ? MEM_BYTE : MEM_WORD;
                    if (is_store) mem_write_d = is_byte ? MEM_BYTE : MEM_WORD;
                end
                if (state_d == S_WB) begin
                    reg_write_d = is_load || is_imm || is_alu;
                    if (is_load)     rb_mux_d = RB_MEM;
                    else if (is_imm) rb_mux_d = RB_IMM;
                    else if (is_alu) rb_mux_d = RB_ALU;
                end
            end
            S_IRQ:  interrupt_d = 1'b1;
            S_HALT: begin
                halted_d = 1'b1;
                branch_d = BR_HALT;
            end
            S_TRAP: trap_d = 1'b1;
            default: trap_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IF;
            ir_q        <= '0;
            wait_q      <= '0;
            stage_q     <= 5'b00001;
            reg_read_q  <= 1'b0;
            reg_write_q <= 1'b0;
            alu_q       <= '0;
            branch_q    <= BR_SEQ;
            mem_read_q  <= MEM_NONE;
            mem_write_q <= MEM_NONE;
            rb_mux_q    <= RB_NONE;
            interrupt_q <= 1'b0;
            halted_q    <= 1'b0;
            trap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            wait_q      <= wait_d;
            stage_q     <= stage_d;
            reg_read_q  <= reg_read_d;
            reg_write_q <= reg_write_d;
            alu_q       <= alu_d;
            branch_q    <= branch_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            rb_mux_q    <= rb_mux_d;
            interrupt_q <= interrupt_d;
            halted_q    <= halted_d;
            trap_q      <= trap_d;
        end
    end

    assign stage         = stage_q;
    assign reg_read      = reg_read_q;
    assign reg_write     = reg_write_q;
    assign alu_opcode    = alu_q;
    assign branch_opcode = branch_q;
    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign rb_mux_opcode = rb_mux_q;
    assign interrupt     = interrupt_q;
    assign halted        = halted_q;
    assign trap          = trap_q;

endmodule

// File: tb/tb_cu_sequencer.sv
// Directed bench for cu_sequencer: walks each instruction class through the FSM and
// checks registered outputs one time unit after every rising edge.
module tb_cu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       instr_valid, mem_ready, irq_ack, resume;
    logic [4:0] stage;
    logic       reg_read, reg_write;
    logic [4:0] alu_opcode;
    logic [2:0] branch_opcode;
    logic [1:0] mem_read, mem_write, rb_mux_opcode;
    logic       interrupt, halted, trap;

    int n_checks = 0;
    int n_errors = 0;

    cu_sequencer u_dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .instr_valid   (instr_valid),
        .mem_ready     (mem_ready),
        .irq_ack       (irq_ack),
        .resume        (resume),
        .stage         (stage),
        .reg_read      (reg_read),
        .reg_write     (reg_write),
        .alu_opcode    (alu_opcode),
        .branch_opcode (branch_opcode),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .rb_mux_opcode (rb_mux_opcode),
        .interrupt     (interrupt),
        .halted        (halted),
        .trap          (trap)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Assert reset between edges and check outputs before any clock edge arrives.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        check_eq("rst_stage", 32'(stage), 32'h01);
        check_eq("rst_mem_read", 32'(mem_read), 32'h0);
        check_eq("rst_branch", 32'(branch_opcode), 32'h3);
        check_eq("rst_trap", 32'(trap), 32'h0);
        check_eq("rst_alu", 32'(alu_opcode), 32'h0);
        step();
        rst = 1'b0;
    endtask

    // From IF: present op, cross IF and ID; returns sampled in the state after ID.
    task automatic fetch(input logic [5:0] op);
        opcode      = op;
        instr_valid = 1'b1;
        check_eq("if_stage", 32'(stage), 32'h01);
        step();
        instr_valid = 1'b0;
        check_eq("id_stage", 32'(stage), 32'h02);
        step();
    endtask

    initial begin
        rst = 1'b1; opcode = '0; instr_valid = 0; mem_ready = 0; irq_ack = 0; resume = 0;
        #12;
        do_reset();
        check_eq("reset_reg_write", 32'(reg_write), 32'h0);
        check_eq("reset_halted", 32'(halted), 32'h0);

        // ADD: IF, ID, EX, WB
        fetch(6'b000001);
        check_eq("add_ex_stage", 32'(stage), 32'h04);
        check_eq("add_ex_alu", 32'(alu_opcode), 32'h01);
        check_eq("add_ex_reg_read", 32'(reg_read), 32'h1);
        step();
        check_eq("add_wb_stage", 32'(stage), 32'h10);
        check_eq("add_wb_reg_write", 32'(reg_write), 32'h1);
        check_eq("add_wb_rb", 32'(rb_mux_opcode), 32'h2);
        check_eq("add_wb_reg_read", 32'(reg_read), 32'h0);
        step();
        check_eq("add_back_if", 32'(stage), 32'h01);
        check_eq("add_if_alu_clr", 32'(alu_opcode), 32'h0);

        // LDI writes back through the immediate path
        fetch(6'b010000);
        check_eq("ldi_ex_alu", 32'(alu_opcode), 32'h0);
        step();
        check_eq("ldi_wb_rb", 32'(rb_mux_opcode), 32'h3);
        check_eq("ldi_wb_reg_write", 32'(reg_write), 32'h1);
        step();

        // LW with three wait cycles
        fetch(6'b011000);
        check_eq("lw_ex_alu", 32'(alu_opcode), 32'h12);
        check_eq("lw_ex_mem_read", 32'(mem_read), 32'h0);
        step();
        for (int i = 0; i < 4; i++) begin
            check_eq("lw_mem_stage", 32'(stage), 32'h08);
            check_eq("lw_mem_read", 32'(mem_read), 32'h3);
            mem_ready = (i == 3);
            step();
        end
        mem_ready = 1'b0;
        check_eq("lw_wb_stage", 32'(stage), 32'h10);
        check_eq("lw_wb_mem_read", 32'(mem_read), 32'h0);
        check_eq("lw_wb_rb", 32'(rb_mux_opcode), 32'h1);
        step();

        // SW with ready arriving on the timeout cycle completes normally
        fetch(6'b011001);
        step();
        for (int i = 0; i < 15; i++) begin
            check_eq("sw_mem_write", 32'(mem_write), 32'h3);
            mem_ready = (i == 14);
            step();
        end
        mem_ready = 1'b0;
        check_eq("sw_edge_stage", 32'(stage), 32'h10);
        check_eq("sw_edge_trap", 32'(trap), 32'h0);
        check_eq("sw_wb_no_write", 32'(reg_write), 32'h0);
        step();

        // SB never answered: trap after 15 MEM cycles, sticky
        fetch(6'b011011);
        check_eq("sb_ex_alu", 32'(alu_opcode), 32'h12);
        step();
        for (int i = 0; i < 15; i++) begin
            check_eq("sb_mem_write", 32'(mem_write), 32'h1);
            check_eq("sb_no_trap_yet", 32'(trap), 32'h0);
            step();
        end
        check_eq("sb_trap", 32'(trap), 32'h1);
        check_eq("sb_trap_strobe", 32'(mem_write), 32'h0);
        instr_valid = 1'b1; mem_ready = 1'b1; resume = 1'b1; irq_ack = 1'b1;
        for (int i = 0; i < 4; i++) step();
        instr_valid = 1'b0; mem_ready = 1'b0; resume = 1'b0; irq_ack = 1'b0;
        check_eq("trap_sticky", 32'(trap), 32'h1);
        check_eq("trap_stage", 32'(stage), 32'h0);
        do_reset();

        // MTC: interrupt held until irq_ack
        opcode = 6'b100000; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            check_eq("mtc_interrupt", 32'(interrupt), 32'h1);
            step();
        end
        check_eq("mtc_interrupt_hold", 32'(interrupt), 32'h1);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check_eq("mtc_int_clr", 32'(interrupt), 32'h0);
        check_eq("mtc_back_if", 32'(stage), 32'h01);

        // HLT: halt, ignore irq_ack/instr_valid, resume, then an invalid opcode traps
        fetch(6'b000000);
        check_eq("hlt_ex_branch", 32'(branch_opcode), 32'h0);
        check_eq("hlt_ex_reg_read", 32'(reg_read), 32'h0);
        step();
        irq_ack = 1'b1; instr_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check_eq("hlt_halted", 32'(halted), 32'h1);
            check_eq("hlt_branch", 32'(branch_opcode), 32'h0);
            step();
        end
        irq_ack = 1'b0; instr_valid = 1'b0; resume = 1'b1;
        step();
        resume = 1'b0;
        check_eq("resume_halted", 32'(halted), 32'h0);
        check_eq("resume_stage", 32'(stage), 32'h01);
        check_eq("resume_branch", 32'(branch_opcode), 32'h3);
        fetch(6'b111111);
        check_eq("inv_trap", 32'(trap), 32'h1);
        do_reset();

        // BEQ: branch code and ALU compare opcode
        fetch(6'b011110);
        check_eq("beq_branch", 32'(branch_opcode), 32'h6);
        check_eq("beq_alu", 32'(alu_opcode), 32'h1e);
        step();
        check_eq("beq_wb_no_write", 32'(reg_write), 32'h0);
        step();

        // async reset mid-MEM of LW
        fetch(6'b011000);
        step();
        step();
        check_eq("lw2_mem_read", 32'(mem_read), 32'h3);
        do_reset();
        check_eq("post_rst_stage", 32'(stage), 32'h01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
